ex_mem_latch: RTL

//  EX/MEM pipeline register for the 5-stage MIPS datapath. Captures the EX-stage results:
//   WB/M control bits, branch target, ALU zero flag and result, store data, and the 5-bit

---
 rtl/ex_mem_if.sv | 26 ++
 rtl/ex_mem_latch.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ex_mem_if.sv
// EX/MEM pipeline bus: valid/ready handshake plus the EX-stage result payload.
// master drives valid and the payload; slave returns ready.
interface ex_mem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
);
  logic              valid;
  logic              ready;
  logic [1:0]        ctlwb;
  logic [2:0]        ctlm;
  logic [DATA_W-1:0] adder;
  logic              aluzero;
  logic [DATA_W-1:0] aluout;
  logic [DATA_W-1:0] readdat2;
  logic [REG_W-1:0]  muxout;

  modport master (
    output valid, ctlwb, ctlm, adder, aluzero, aluout, readdat2, muxout,
    input  ready
  );

  modport slave (
    input  valid, ctlwb, ctlm, adder, aluzero, aluout, readdat2, muxout,
    output ready
  );
endinterface

// File: rtl/ex_mem_latch.sv
// EX/MEM elastic pipeline register with a 2-entry skid buffer, branch flush and
// forwarding taps taken from the oldest held entry.
module ex_mem_latch #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  ex_mem_if.slave          ex_i,
  ex_mem_if.master         mem_o,
  output logic             fwd_regwrite,
  output logic [REG_W-1:0] fwd_dest
);

  typedef struct packed {
    logic [1:0]        ctlwb;
    logic [2:0]        ctlm;
    logic [DATA_W-1:0] adder;
    logic              aluzero;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] readdat2;
    logic [REG_W-1:0]  muxout;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   in_ready_q, out_valid_q;
  logic   in_fire, out_fire;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   load_main_in, load_main_skid, load_skid;

  assign in_fire  = ex_i.valid & in_ready_q & ~flush;
  assign out_fire = out_valid_q & mem_o.ready;

  // Pack the incoming EX-stage fields into one entry.
  always_comb begin
    in_entry          = '0;
    in_entry.ctlwb    = ex_i.ctlwb;
    in_entry.ctlm     = ex_i.ctlm;
    in_entry.adder    = ex_i.adder;
    in_entry.aluzero  = ex_i.aluzero;
    in_entry.aluout   = ex_i.aluout;
    in_entry.readdat2 = ex_i.readdat2;
    in_entry.muxout   = ex_i.muxout;
  end

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != S_SKID);
      out_valid_q <= (state_d != S_EMPTY);
    end
  end

  // Next-state logic; flush wins over any transfer.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (in_fire) state_d = S_FULL;
        S_FULL: begin
          if (in_fire && !out_fire)      state_d = S_SKID;
          else if (!in_fire && out_fire) state_d = S_EMPTY;
        end
        S_SKID:  if (out_fire) state_d = S_FULL;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Datapath load enables and next values for the main and skid entries.
  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    main_d         = main_q;
    skid_d         = skid_q;
    if (!flush) begin
      case (state_q)
        S_EMPTY: load_main_in = in_fire;
        S_FULL: begin
          load_main_in = in_fire & out_fire;
          load_skid    = in_fire & ~out_fire;
        end
        S_SKID:  load_main_skid = out_fire;
        default: ;
      endcase
    end
    if (load_main_in)        main_d = in_entry;
    else if (load_main_skid) main_d = skid_q;
    if (load_skid)           skid_d = in_entry;
  end

  // Payload storage; flush leaves stale data behind, masked by out_valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign ex_i.ready     = in_ready_q;
  assign mem_o.valid    = out_valid_q;
  // A write to register 0 is never a real write-back.
  assign mem_o.ctlwb    = {main_q.ctlwb[1] & (main_q.muxout != '0), main_q.ctlwb[0]};
  assign mem_o.ctlm     = main_q.ctlm;
  assign mem_o.adder    = main_q.adder;
  assign mem_o.aluzero  = main_q.aluzero;
  assign mem_o.aluout   = main_q.aluout;
  assign mem_o.readdat2 = main_q.readdat2;
  assign mem_o.muxout   = main_q.muxout;

  assign fwd_regwrite = out_valid_q & main_q.ctlwb[1] & (main_q.muxout != '0);
  assign fwd_dest     = main_q.muxout;

endmodule
